// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle of seg_scan_ctrl: base/overlay sources, overlay handshake
// and the active-low digit/segment pins.
interface seg_scan_ctrl_if;
   logic [15:0] base_val;
   logic [3:0]  base_dp;
   logic [3:0]  base_blank;
   logic        ovl_req;
   logic [15:0] ovl_val;
   logic        ovl_ack;
   logic        ovl_active;
   logic        AN0, AN1, AN2, AN3;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output base_val, base_dp, base_blank, ovl_req, ovl_val,
      input  ovl_ack, ovl_active, AN0, AN1, AN2, AN3, seg, dp
   );

   modport slave (
      input  base_val, base_dp, base_blank, ovl_req, ovl_val,
      output ovl_ack, ovl_active, AN0, AN1, AN2, AN3, seg, dp
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scanner with base/overlay arbitration.
// Optional anode dead time at each slot start: define SEG_GHOST_GUARD_EN (needs SCAN_DIV > 8).
module seg_scan_ctrl #(
   parameter int SCAN_DIV    = 65536,
   parameter int HOLD_FRAMES = 64
) (
   input  logic            clkin,
   input  logic            reset,
   seg_scan_ctrl_if.slave  bus
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int HW = $clog2(HOLD_FRAMES + 1);

   typedef enum logic [1:0] {D0, D1, D2, D3} digit_e;

   digit_e          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            lit_q, lit_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            active_q, active_d;
   logic            ack_q, ack_d;
   logic [15:0]     ovl_q, ovl_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [3:0]      an_vis;
   logic [3:0]      nib;
   logic [1:0]      sel;
   logic            tick, frame;

   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      case (h)
         4'h0: hex2seg = 7'h40;  4'h1: hex2seg = 7'h79;
         4'h2: hex2seg = 7'h24;  4'h3: hex2seg = 7'h30;
         4'h4: hex2seg = 7'h19;  4'h5: hex2seg = 7'h12;
         4'h6: hex2seg = 7'h02;  4'h7: hex2seg = 7'h78;
         4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h10;
         4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h03;
         4'hC: hex2seg = 7'h46;  4'hD: hex2seg = 7'h21;
         4'hE: hex2seg = 7'h06;  default: hex2seg = 7'h0E;
      endcase
   endfunction

   assign tick  = (cnt_q == CW'(SCAN_DIV - 1));
   // lit_q distinguishes the dark period after reset from a real D3->D0 wrap
   assign frame = tick && lit_q && (state_q == D3);

   always_ff @(posedge clkin) begin
      if (reset) begin
         cnt_q    <= '0;
         state_q  <= D0;
         lit_q    <= 1'b0;
         hold_q   <= '0;
         active_q <= 1'b0;
         ack_q    <= 1'b0;
         ovl_q    <= '0;
         an_q     <= 4'hF;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
      end else begin
         cnt_q    <= tick ? '0 : cnt_q + CW'(1);
         state_q  <= state_d;
         lit_q    <= lit_d;
         hold_q   <= hold_d;
         active_q <= active_d;
         ack_q    <= ack_d;
         ovl_q    <= ovl_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      lit_d    = lit_q;
      hold_d   = hold_q;
      active_d = active_q;
      ack_d    = bus.ovl_req;
      ovl_d    = ovl_q;
      an_d     = an_q;
      seg_d    = seg_q;
      dp_d     = dp_q;
      nib      = 4'h0;
      sel      = 2'd0;

      // a fresh request beats a hold expiring on the same edge
      if (bus.ovl_req) begin
         active_d = 1'b1;
         hold_d   = HW'(HOLD_FRAMES);
         ovl_d    = bus.ovl_val;
      end else if (frame && active_q) begin
         hold_d = hold_q - HW'(1);
         if (hold_q == HW'(1))
            active_d = 1'b0;
      end

      if (tick) begin
         lit_d = 1'b1;
         if (lit_q) begin
            case (state_q)
               D0:      state_d = D1;
               D1:      state_d = D2;
               D2:      state_d = D3;
               default: state_d = D0;
            endcase
         end
         sel  = state_d;
         an_d = ~(4'b0001 << sel);
         if (active_d) begin
            nib   = ovl_d[{sel, 2'b00} +: 4];
            seg_d = hex2seg(nib);
            dp_d  = 1'b1;
         end else if (bus.base_blank[sel]) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
         end else begin
            nib   = bus.base_val[{sel, 2'b00} +: 4];
            seg_d = hex2seg(nib);
            dp_d  = ~bus.base_dp[sel];
         end
      end
   end

`ifdef SEG_GHOST_GUARD_EN
   assign an_vis = an_q | {4{cnt_q < CW'(8)}};
`else
   assign an_vis = an_q;
`endif

   assign bus.AN0        = an_vis[0];
   assign bus.AN1        = an_vis[1];
   assign bus.AN2        = an_vis[2];
   assign bus.AN3        = an_vis[3];
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.ovl_ack    = ack_q;
   assign bus.ovl_active = active_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl against a frame-level reference model.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;
`ifdef SEG_GHOST_GUARD_EN
   localparam int SD = 16;
`else
   localparam int SD = 4;
`endif
   localparam int HF = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg_scan_ctrl_if bus();
   seg_scan_ctrl #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (.clkin(clk), .reset(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference state: cycles since reset, digits shown so far, overlay frames left
   int          m_cnt = 0, m_ticks = 0, m_left = 0;
   bit          m_active = 0, m_ack = 0;
   logic [15:0] m_val = '0;
   logic [3:0]  m_an = 4'hF;
   logic [6:0]  m_seg = 7'h7F;
   logic        m_dp = 1'b1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input logic [15:0] bv, input logic [3:0] bdp,
                             input logic [3:0] bbl, input bit req, input logic [15:0] ov);
      int k;
      bit tck, frm;
      logic [3:0] nb;
      if (r) begin
         m_cnt = 0; m_ticks = 0; m_left = 0; m_active = 0; m_ack = 0; m_val = '0;
         m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
         m_cnt++;
         tck = (m_cnt % SD == 0);
         frm = tck && (m_ticks > 0) && (m_ticks % 4 == 0);
         m_ack = req;
         if (req) begin
            m_active = 1; m_left = HF; m_val = ov;
         end else if (frm && m_active) begin
            m_left--;
            if (m_left == 0) m_active = 0;
         end
         if (tck) begin
            k = m_ticks % 4;
            m_ticks++;
            m_an = 4'hF;
            m_an[k] = 1'b0;
            if (m_active) begin
               nb = 4'((m_val >> (4 * k)) & 16'hF);
               m_seg = segtab[nb]; m_dp = 1'b1;
            end else if (bbl[k]) begin
               m_seg = 7'h7F; m_dp = 1'b1;
            end else begin
               nb = 4'((bv >> (4 * k)) & 16'hF);
               m_seg = segtab[nb]; m_dp = ~bdp[k];
            end
         end
      end
   endtask

   function automatic logic [3:0] exp_an();
`ifdef SEG_GHOST_GUARD_EN
      if (m_cnt % SD < 8) return 4'hF;
`endif
      return m_an;
   endfunction

   function automatic bit next_is_expiry();
      return m_active && (m_left == 1) && ((m_cnt + 1) % SD == 0) &&
             (m_ticks > 0) && (m_ticks % 4 == 0);
   endfunction

   task automatic step();
      bit          r   = rst;
      logic [15:0] bv  = bus.base_val;
      logic [3:0]  bdp = bus.base_dp;
      logic [3:0]  bbl = bus.base_blank;
      bit          rq  = bus.ovl_req;
      logic [15:0] ov  = bus.ovl_val;
      @(posedge clk);
      model_edge(r, bv, bdp, bbl, rq, ov);
      #1;
      chk("an",     {12'h0, bus.AN3, bus.AN2, bus.AN1, bus.AN0}, {12'h0, exp_an()});
      chk("seg",    {9'h0, bus.seg}, {9'h0, m_seg});
      chk("dp",     {15'h0, bus.dp}, {15'h0, m_dp});
      chk("ack",    {15'h0, bus.ovl_ack}, {15'h0, m_ack});
      chk("active", {15'h0, bus.ovl_active}, {15'h0, m_active});
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      bus.base_val = 16'h0; bus.base_dp = 4'h0; bus.base_blank = 4'h0;
      bus.ovl_req = 1'b0; bus.ovl_val = 16'h0;

      // reset and first scan of 1234
      rst = 1'b1;
      steps(2);
      chk("reset_seg", {9'h0, bus.seg}, 16'h007F);
      rst = 1'b0;
      bus.base_val = 16'h1234;
      steps(SD - 1);
      chk("dark_seg", {9'h0, bus.seg}, 16'h007F);
      step();
      chk("digit0_seg", {9'h0, bus.seg}, 16'h0019);
      steps(SD);
      chk("digit1_seg", {9'h0, bus.seg}, 16'h0030);
      steps(SD);
      chk("digit2_seg", {9'h0, bus.seg}, 16'h0024);
      steps(SD);
      chk("digit3_seg", {9'h0, bus.seg}, 16'h0079);

      // blanking and decimal point
      bus.base_blank = 4'b0010; bus.base_dp = 4'b0001;
      steps(SD);
      chk("dp_digit0", {15'h0, bus.dp}, 16'h0000);
      steps(SD);
      chk("blank_digit1", {9'h0, bus.seg}, 16'h007F);
      steps(2 * SD);

      // single overlay request
      bus.ovl_req = 1'b1; bus.ovl_val = 16'hABCD;
      step();
      chk("ack_pulse", {15'h0, bus.ovl_ack}, 16'h0001);
      bus.ovl_req = 1'b0;
      step();
      chk("ack_drop", {15'h0, bus.ovl_ack}, 16'h0000);
      steps(12 * SD);

      // re-request while active, then a request on the expiring edge
      bus.ovl_req = 1'b1; bus.ovl_val = 16'h1111;
      step();
      bus.ovl_req = 1'b0;
      steps(5);
      bus.ovl_req = 1'b1; bus.ovl_val = 16'h5E6F;
      step();
      bus.ovl_req = 1'b0;
      chk("rereq_ack", {15'h0, bus.ovl_ack}, 16'h0001);
      guard = 0;
      while (!next_is_expiry() && guard < 20 * SD) begin
         step();
         guard++;
      end
      if (!next_is_expiry()) begin
         checks++; errors++;
         $error("FAIL expiry_wait observed=timeout expected=expiry edge");
      end
      bus.ovl_req = 1'b1; bus.ovl_val = 16'h9876;
      step();
      bus.ovl_req = 1'b0;
      chk("expiry_req_active", {15'h0, bus.ovl_active}, 16'h0001);
      steps(4 * SD);

      // reset in the middle of the D2 slot
      guard = 0;
      while (!(m_active && (m_ticks % 4 == 3) && (m_cnt % SD == 1)) && guard < 20 * SD) begin
         step();
         guard++;
      end
      if (!(m_active && (m_ticks % 4 == 3))) begin
         checks++; errors++;
         $error("FAIL d2_wait observed=timeout expected=overlay in D2");
      end
      rst = 1'b1;
      step();
      chk("midrst_seg", {9'h0, bus.seg}, 16'h007F);
      chk("midrst_an", {12'h0, bus.AN3, bus.AN2, bus.AN1, bus.AN0}, 16'h000F);
      chk("midrst_active", {15'h0, bus.ovl_active}, 16'h0000);
      rst = 1'b0;
      steps(SD);
      chk("restart_digit0", {9'h0, bus.seg}, 16'h0019);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            bus.base_val   = 16'($urandom);
            bus.base_dp    = 4'($urandom);
            bus.base_blank = 4'($urandom);
         end
         bus.ovl_req = ($urandom_range(0, 39) == 0);
         bus.ovl_val = 16'($urandom);
         rst         = ($urandom_range(0, 599) == 0);
         step();
      end
      rst = 1'b0;
      bus.ovl_req = 1'b0;
      steps(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
